// File: rtl/hci_mem_bank_responder.sv
// Single-port TCDM bank behind an HCI log-interconnect port: one-cycle read latency, byte-enabled
// writes, test-and-set lock. Define HCI_MEM_BANK_STALL_EN to add LFSR-driven grant stalls.
module hci_mem_bank_responder #(
  parameter int unsigned NWORDS = 1024,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = 8,
  parameter int unsigned IW     = 8,
  parameter int unsigned TS_BIT = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    data_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [IW-1:0]    id_i,
  output logic             gnt_o,
  output logic [DW-1:0]    r_data_o,
  output logic             r_valid_o,
  output logic [IW-1:0]    r_id_o
);

  localparam int unsigned IDXW = $clog2(NWORDS);
  localparam int unsigned BEW  = DW / BW;

  typedef enum logic {
    IDLE,
    TS_LOCK
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     mem [NWORDS];
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   ts_idx;
  logic              stall;
  logic              ts_req;
  logic              unused_addr;

  assign idx         = add_i[IDXW+1:2];
  assign unused_addr = ^{add_i[AW-1:IDXW+2], add_i[1:0]};

`ifdef HCI_MEM_BANK_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stall   = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    ts_req  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o  = req_i & ~stall;
        ts_req = gnt_o & wen_i & add_i[TS_BIT];
        if (ts_req) state_d = TS_LOCK;
      end
      TS_LOCK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage is not reset; an async reset during TS_LOCK drops state to IDLE, aborting the lock write
  always_ff @(posedge clk_i) begin
    if (state_q == TS_LOCK) begin
      mem[ts_idx] <= '1;
    end else if (gnt_o && !wen_i) begin
      for (int unsigned k = 0; k < BEW; k++) begin
        if (be_i[k]) mem[idx][k*BW +: BW] <= data_i[k*BW +: BW];
      end
    end
  end

  // Response stage: everything visible one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_id_o    <= '0;
      ts_idx    <= '0;
    end else begin
      r_valid_o <= gnt_o;
      if (gnt_o) r_id_o <= id_i;
      if (gnt_o && wen_i) r_data_o <= mem[idx];
      if (ts_req) ts_idx <= idx;
    end
  end

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Scoreboard bench for hci_mem_bank_responder; follows HCI_MEM_BANK_STALL_EN when it is defined.
module tb_hci_mem_bank_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned NW = 1024;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_i;
  logic [AW-1:0]    add_i;
  logic             wen_i;
  logic [DW-1:0]    data_i;
  logic [DW/BW-1:0] be_i;
  logic [IW-1:0]    id_i;
  logic             gnt_o;
  logic [DW-1:0]    r_data_o;
  logic             r_valid_o;
  logic [IW-1:0]    r_id_o;

  always #5 clk_i = ~clk_i;

  hci_mem_bank_responder #(
    .NWORDS(NW), .AW(AW), .DW(DW), .BW(BW), .IW(IW), .TS_BIT(20)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .data_i(data_i), .be_i(be_i), .id_i(id_i), .gnt_o(gnt_o), .r_data_o(r_data_o),
    .r_valid_o(r_valid_o), .r_id_o(r_id_o)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] mem_m [NW];
  logic          lock_pend;
  logic [9:0]    lock_idx;
  logic [DW-1:0] exp_rdata;
  logic [15:0]   lfsr_m;
  int            n_vec, n_err, n_gnt, n_rvld;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic model_gnt(input logic req);
`ifdef HCI_MEM_BANK_STALL_EN
    return req && !lock_pend && (lfsr_m[1:0] != 2'b00);
`else
    return req && !lock_pend;
`endif
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Called at posedge+1; drives one cycle and checks its grant and response.
  task automatic step(input logic req, input logic [AW-1:0] add, input logic wen,
                      input logic [DW-1:0] data, input logic [3:0] be, input logic [IW-1:0] id,
                      output logic granted);
    logic [9:0] idx;
    logic       old_lock, new_lock;
    rsp_t       r;
    req_i = req; add_i = add; wen_i = wen; data_i = data; be_i = be; id_i = id;
    #3;
    granted  = model_gnt(req);
    old_lock = lock_pend;
    new_lock = 1'b0;
    check("gnt", gnt_o, granted);
    if (granted) begin
      idx = add[11:2];
      if (wen) begin
        exp_rdata = mem_m[idx];
        if (add[20]) begin
          new_lock = 1'b1;
          lock_idx = idx;
        end
      end else begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mem_m[idx][k*8 +: 8] = data[k*8 +: 8];
      end
      sb.push_back({id, exp_rdata});
      n_gnt++;
    end
    @(posedge clk_i);
    #1;
    if (old_lock) begin
      mem_m[lock_idx] = '1;
      lock_pend = 1'b0;
    end
    if (new_lock) lock_pend = 1'b1;
    lfsr_m = lfsr_next(lfsr_m);
    if (r_valid_o) n_rvld++;
    check("r_valid", r_valid_o, sb.size() != 0);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      check("r_id", r_id_o, r.id);
      check("r_data", r_data_o, r.data);
    end
  endtask

  // Holds the request until the model says it is granted.
  task automatic access(input logic [AW-1:0] add, input logic wen, input logic [DW-1:0] data,
                        input logic [3:0] be, input logic [IW-1:0] id);
    logic g;
    g = 1'b0;
    for (int t = 0; t < 40 && !g; t++) step(1'b1, add, wen, data, be, id, g);
    if (!g) check("access_timeout", 64'd0, 64'd1);
  endtask

  logic g0;
  logic [AW-1:0] rnd_add [5];

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b0; data_i = '0; be_i = '0; id_i = '0;
    lock_pend = 1'b0; lock_idx = '0; exp_rdata = '0; lfsr_m = 16'hACE1;
    n_vec = 0; n_err = 0; n_gnt = 0; n_rvld = 0;
    rnd_add[0] = 32'h10; rnd_add[1] = 32'h20; rnd_add[2] = 32'h40;
    rnd_add[3] = 32'h30; rnd_add[4] = 32'h80;

    repeat (3) begin
      @(posedge clk_i);
      #1;
      check("rst_gnt", gnt_o, 1'b0);
      check("rst_valid", r_valid_o, 1'b0);
      check("rst_data", r_data_o, '0);
      check("rst_id", r_id_o, '0);
    end
    rst_ni = 1'b1;
    repeat (3) begin
      step(1'b0, '0, 1'b0, '0, '0, '0, g0);
      check("idle_data", r_data_o, '0);
      check("idle_id", r_id_o, '0);
    end

    access(32'h10, 1'b0, 32'hDEADBEEF, 4'hF, 8'd3);
    access(32'h10, 1'b1, '0, '0, 8'd5);
    check("wr_rd", r_data_o, 32'hDEADBEEF);

    access(32'h20, 1'b0, 32'h11223344, 4'hF, 8'd1);
    access(32'h20, 1'b0, 32'hAABBCCDD, 4'b0101, 8'd2);
    access(32'h20, 1'b1, '0, '0, 8'd4);
    check("be_merge", r_data_o, 32'h11BB33DD);

    access(32'h40, 1'b0, 32'h0, 4'hF, 8'd6);
    access(32'h40 | (32'd1 << 20), 1'b1, '0, '0, 8'd7);
    check("ts_old", r_data_o, 32'h0);
    access(32'h40, 1'b1, '0, '0, 8'd8);
    check("ts_locked", r_data_o, 32'hFFFFFFFF);

    access(32'h30 | (32'd1 << 20), 1'b0, 32'h12345678, 4'hF, 8'd9);
    access(32'h30, 1'b1, '0, '0, 8'd10);
    check("ts_bit_write", r_data_o, 32'h12345678);

    access(32'h0200_1013, 1'b0, 32'hCAFEF00D, 4'hF, 8'd20);
    access(32'h10, 1'b1, '0, '0, 8'd21);
    check("wrap_alias", r_data_o, 32'hCAFEF00D);

    access(32'h80, 1'b0, 32'h5, 4'hF, 8'd11);
    access(32'h80 | (32'd1 << 20), 1'b1, '0, '0, 8'd12);
    req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_ts_valid", r_valid_o, 1'b0);
    check("rst_ts_data", r_data_o, '0);
    check("rst_ts_id", r_id_o, '0);
    rst_ni = 1'b1;
    lock_pend = 1'b0; exp_rdata = '0; lfsr_m = 16'hACE1;
    @(posedge clk_i);
    #1;
    lfsr_m = lfsr_next(lfsr_m);
    access(32'h80, 1'b1, '0, '0, 8'd13);
    check("rst_ts_kept", r_data_o, 32'h5);

    for (int i = 0; i < 64; i++) begin
      logic w;
      w = ($urandom_range(0, 3) == 0);
      step(1'b1, rnd_add[$urandom_range(0, 4)], ~w, $urandom, 4'($urandom), 8'(i + 64), g0);
    end
    step(1'b0, '0, 1'b0, '0, '0, '0, g0);
    check("rvld_count", n_rvld, n_gnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
